uart_rx_framer: RTL and testbench
=================================

// Module: uart_rx_framer
// PURPOSE
//  Serial receive front end of the UART path: oversampled 8N1 receiver that turns the rx pin into bytes.
//  Sits directly upstream of the datapath receive FIFO: data_out feeds fifo data_in, data_valid drives fifo write.
//  Runs on the single system clock; no clock crossing beyond the rx pin synchroniser.
//  Reports framing and overrun errors as sticky flags for software/debug readout.
// PARAMETERS
//  CLKS_PER_BIT  868  system clocks per bit (100 MHz / 115200); must be >= 4
//  OUT_WIDTH     32   width of data_out; received byte zero-extended to this width
// PORTS
//  clk          in   1          system clock, all logic on rising edge
//  reset        in   1          synchronous, active-low reset (reset==0 resets on next clk edge)
//  rx           in   1          asynchronous serial line, idle high
//  rx_enable    in   1          1 = receiver armed; 0 = hold/abort to IDLE
//  fifo_full    in   1          downstream FIFO cannot accept a write this cycle
//  err_clear    in   1          1-cycle pulse clears both sticky error flags
//  data_out     out  OUT_WIDTH  last received byte, zero-extended; stable until next data_valid
//  data_valid   out  1          1-cycle write strobe to FIFO; data_out valid in same cycle
//  busy         out  1          1 in any state other than IDLE
//  frame_err    out  1          sticky: stop bit sampled as 0
//  overrun      out  1          sticky: byte completed while fifo_full=1 (byte dropped)
// BEHAVIOUR
//  Reset: state=IDLE, sync flops=1, counters=0, data_out=0, data_valid=0, busy=0, frame_err=0, overrun=0.
//  rx passes 2-flop synchroniser (rx_s); all decisions use rx_s; 2-cycle pin-to-FSM latency.
//  bit_cnt counts 0..CLKS_PER_BIT-1, cleared on every state entry; idx counts data bits 0..7.
//  IDLE: if rx_enable && rx_s==0 -> START.
//  START: at bit_cnt==CLKS_PER_BIT/2-1 (integer div): rx_s==0 -> DATA (idx=0); rx_s==1 -> IDLE, glitch, no output.
//  DATA: at bit_cnt==CLKS_PER_BIT-1 shift rx_s into shreg LSB-first (shreg[idx]); idx==7 -> STOP, else idx++.
//  STOP: at bit_cnt==CLKS_PER_BIT-1 sample rx_s:
//    rx_s==1 && !fifo_full -> data_out<={0,shreg}, data_valid=1 next cycle, -> IDLE.
//    rx_s==1 && fifo_full  -> overrun<=1, data_out unchanged, no strobe, -> IDLE.
//    rx_s==0               -> frame_err<=1, no strobe, -> BREAK.
//  BREAK: wait for rx_s==1, then -> IDLE (line-break held low never produces bytes).
//  data_valid registered: exactly one cycle high per accepted byte, never two consecutive cycles.
//  Sampling at mid-stop then IDLE gives half-bit margin: back-to-back frames with no idle gap are received.
//  rx_enable=0 in any state: -> IDLE next cycle, partial byte discarded, no flags touched.
//  err_clear and new error same cycle: error set wins.
//  reset low mid-frame: all state/outputs to reset values; next falling edge starts a clean frame.
//  fifo_full only sampled at stop decision; its value at other times is ignored.
// TESTING (bench with CLKS_PER_BIT=16, rx driven 16 clks per bit)
//  Frame 0xA5, stop=1, fifo_full=0 -> one data_valid pulse, data_out=0x000000A5, frame_err=0, overrun=0.
//  rx low 5 clks then high (glitch < 8 clks) -> busy returns 0, no data_valid, data_out unchanged.
//  Frame 0x3C with stop=0, rx held low 40 clks -> no data_valid, frame_err=1, busy=1 until rx high; err_clear -> frame_err=0.
//  Frame 0x55 with fifo_full=1 at stop -> overrun=1, no strobe; next frame 0x0F fifo_full=0 -> data_out=0x0000000F.
//  Back-to-back 0x00 then 0xFF, no idle gap -> two data_valid pulses, data_out 0x00 then 0xFF.
//  reset=0 for 1 clk during data bit 4, then frame 0x81 -> outputs 0 after reset, then data_out=0x00000081.

Source files
------------

// File: rtl/uart_rx_framer.sv
// Oversampled 8N1 UART receiver: synchronises the rx pin, frames bytes and
// writes them to the downstream FIFO, with sticky framing/overrun flags.
module uart_rx_framer #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned OUT_WIDTH    = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx,
  input  logic                 i_rx_enable,
  input  logic                 i_fifo_full,
  input  logic                 i_err_clear,
  output logic [OUT_WIDTH-1:0] o_data_out,
  output logic                 o_data_valid,
  output logic                 o_busy,
  output logic                 o_frame_err,
  output logic                 o_overrun
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_rx_meta;
  logic                   r_rx_s;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [2:0]             r_idx;
  logic [7:0]             r_shreg;
  logic [OUT_WIDTH-1:0]   r_data_out;
  logic                   r_data_valid;
  logic                   r_busy;
  logic                   r_frame_err;
  logic                   r_overrun;
  logic                   w_shift;
  logic                   w_accept;
  logic                   w_ovr_set;
  logic                   w_fe_set;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state and per-cycle datapath controls
  always_comb begin
    w_next    = r_state;
    w_shift   = 1'b0;
    w_accept  = 1'b0;
    w_ovr_set = 1'b0;
    w_fe_set  = 1'b0;
    case (r_state)
      S_IDLE:  if (!r_rx_s) w_next = S_START;
      S_START: if (r_bit_cnt == CNT_HALF) w_next = r_rx_s ? S_IDLE : S_DATA;
      S_DATA: begin
        if (r_bit_cnt == CNT_LAST) begin
          w_shift = 1'b1;
          if (r_idx == 3'd7) w_next = S_STOP;
        end
      end
      S_STOP: begin
        if (r_bit_cnt == CNT_LAST) begin
          if (r_rx_s) begin
            w_ovr_set = i_fifo_full;
            w_accept  = !i_fifo_full;
            w_next    = S_IDLE;
          end else begin
            w_fe_set = 1'b1;
            w_next   = S_BREAK;
          end
        end
      end
      S_BREAK: if (r_rx_s) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // Disarm aborts any frame without touching the flags
    if (!i_rx_enable) begin
      w_next    = S_IDLE;
      w_shift   = 1'b0;
      w_accept  = 1'b0;
      w_ovr_set = 1'b0;
      w_fe_set  = 1'b0;
    end
  end

  // Pin synchroniser, bit timing, shift register and registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_rx_meta    <= 1'b1;
      r_rx_s       <= 1'b1;
      r_bit_cnt    <= '0;
      r_idx        <= '0;
      r_shreg      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_s    <= r_rx_meta;

      if (w_next != r_state || r_bit_cnt == CNT_LAST) r_bit_cnt <= '0;
      else                                             r_bit_cnt <= r_bit_cnt + CNT_W'(1);

      if (r_state != S_DATA) r_idx <= '0;
      else if (w_shift)      r_idx <= r_idx + 3'd1;

      if (w_shift) r_shreg[r_idx] <= r_rx_s;

      if (w_accept) r_data_out <= OUT_WIDTH'(r_shreg);
      r_data_valid <= w_accept;
      r_busy       <= (w_next != S_IDLE);

      if (w_fe_set)         r_frame_err <= 1'b1;
      else if (i_err_clear) r_frame_err <= 1'b0;

      if (w_ovr_set)        r_overrun <= 1'b1;
      else if (i_err_clear) r_overrun <= 1'b0;
    end
  end

  assign o_data_out   = r_data_out;
  assign o_data_valid = r_data_valid;
  assign o_busy       = r_busy;
  assign o_frame_err  = r_frame_err;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer: directed frames plus randomized frames checked
// against a frame-level model of the expected bytes and sticky flags.
module tb_uart_rx_framer;

  localparam int unsigned CPB = 16;
  localparam int unsigned OW  = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          rx;
  logic          rx_enable;
  logic          fifo_full;
  logic          err_clear;
  logic [OW-1:0] data_out;
  logic          data_valid;
  logic          busy;
  logic          frame_err;
  logic          overrun;

  int total = 0;
  int bad   = 0;

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_dout;
  logic        exp_fe;
  logic        exp_ov;
  logic        prev_valid  = 1'b0;
  int          consec_viol = 0;
  logic        busy_seen   = 1'b0;

  uart_rx_framer #(.CLKS_PER_BIT(CPB), .OUT_WIDTH(OW)) dut (
    .i_clk       (clk),
    .i_reset     (reset_n),
    .i_rx        (rx),
    .i_rx_enable (rx_enable),
    .i_fifo_full (fifo_full),
    .i_err_clear (err_clear),
    .o_data_out  (data_out),
    .o_data_valid(data_valid),
    .o_busy      (busy),
    .o_frame_err (frame_err),
    .o_overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Capture every write strobe and flag strobes that last two cycles
  always @(negedge clk) begin
    if (data_valid) got_q.push_back(data_out);
    if (data_valid && prev_valid) consec_viol++;
    prev_valid = data_valid;
    if (busy) busy_seen = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic ff);
    rx        = b;
    fifo_full = ff;
    tick(CPB);
  endtask

  // One 8N1 frame; fifo_full is random except during the stop bit when rand_ff is set
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic ff_stop,
                            input logic rand_ff);
    send_bit(1'b0, rand_ff ? 1'($urandom) : 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], rand_ff ? 1'($urandom) : 1'b0);
    send_bit(stop_b, ff_stop);
    fifo_full = 1'b0;
  endtask

  // Frame-level reference: outcome depends only on stop bit and fifo_full at stop
  task automatic model_frame(input logic [7:0] d, input logic stop_b, input logic ff);
    if (!stop_b)  exp_fe = 1'b1;
    else if (ff)  exp_ov = 1'b1;
    else begin
      exp_dout = 32'(d);
      exp_q.push_back(32'(d));
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_dout"}, data_out, exp_dout);
    check({tag, "_fe"},   32'(frame_err), 32'(exp_fe));
    check({tag, "_ov"},   32'(overrun),   32'(exp_ov));
  endtask

  task automatic compare_q(input string tag);
    int n;
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_byte"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    logic       stop_b;
    logic       ff;
    int         gap;

    reset_n = 1'b0; rx = 1'b1; rx_enable = 1'b1; fifo_full = 1'b0; err_clear = 1'b0;
    exp_dout = '0; exp_fe = 1'b0; exp_ov = 1'b0;
    tick(3);
    check("rst_dout",  data_out, 32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_fe",    32'(frame_err), 32'h0);
    check("rst_ov",    32'(overrun), 32'h0);
    reset_n = 1'b1;
    tick(5);

    // Clean frame
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0); model_frame(8'hA5, 1'b1, 1'b0);
    tick(2);
    check_outputs("a5");
    compare_q("a5");

    // Short low glitch: start rejected at mid-bit
    busy_seen = 1'b0;
    rx = 1'b0; tick(5); rx = 1'b1; tick(20);
    check("glitch_busy_seen", 32'(busy_seen), 32'h1);
    check("glitch_busy", 32'(busy), 32'h0);
    check_outputs("glitch");
    compare_q("glitch");

    // Framing error with line held low, then break release and clear
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0); model_frame(8'h3C, 1'b0, 1'b0);
    rx = 1'b0; tick(24);
    check("brk_busy", 32'(busy), 32'h1);
    check_outputs("brk");
    rx = 1'b1; tick(4);
    check("brk_release_busy", 32'(busy), 32'h0);
    err_clear = 1'b1; tick(1); err_clear = 1'b0; exp_fe = 1'b0;
    check("brk_cleared_fe", 32'(frame_err), 32'h0);
    compare_q("brk");
    tick(CPB);

    // Overrun, then a good frame
    send_frame(8'h55, 1'b1, 1'b1, 1'b0); model_frame(8'h55, 1'b1, 1'b1);
    tick(2);
    check_outputs("ovr");
    send_frame(8'h0F, 1'b1, 1'b0, 1'b0); model_frame(8'h0F, 1'b1, 1'b0);
    tick(2);
    check_outputs("after_ovr");
    compare_q("ovr");

    // Back-to-back frames with no idle gap
    send_frame(8'h00, 1'b1, 1'b0, 1'b0); model_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0); model_frame(8'hFF, 1'b1, 1'b0);
    tick(2);
    check_outputs("b2b");
    compare_q("b2b");

    // Disarm mid-frame: abort with flags untouched, low line ignored while disarmed
    send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    rx_enable = 1'b0; tick(2);
    check("dis_busy", 32'(busy), 32'h0);
    rx = 1'b0; tick(CPB);
    check("dis_low_busy", 32'(busy), 32'h0);
    rx = 1'b1; tick(2 * CPB);
    rx_enable = 1'b1; tick(CPB);
    check_outputs("dis");
    compare_q("dis");

    // Reset pulse during data bit 4, then a clean frame
    d = 8'h81;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i], 1'b0);
    rx = d[4]; tick(5);
    rx = 1'b1; reset_n = 1'b0; tick(1); reset_n = 1'b1;
    exp_dout = '0; exp_fe = 1'b0; exp_ov = 1'b0;
    check("rst2_busy", 32'(busy), 32'h0);
    check("rst2_valid", 32'(data_valid), 32'h0);
    check_outputs("rst2");
    tick(2 * CPB);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0); model_frame(8'h81, 1'b1, 1'b0);
    tick(2);
    check_outputs("post_rst");
    compare_q("post_rst");

    // Randomized frames: random data, stop bit, fifo_full, gaps and clears
    for (int k = 0; k < 24; k++) begin
      d      = 8'($urandom);
      stop_b = ($urandom_range(0, 4) != 0);
      ff     = ($urandom_range(0, 2) == 0);
      gap    = $urandom_range(0, 2);
      send_frame(d, stop_b, ff, 1'b1);
      model_frame(d, stop_b, ff);
      check_outputs("rnd");
      if (!stop_b) begin
        rx = 1'b0; tick($urandom_range(0, 20));
        rx = 1'b1; tick(CPB);
      end
      if (gap > 0) begin
        rx = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
          tick(2);
          err_clear = 1'b1; tick(1); err_clear = 1'b0;
          exp_fe = 1'b0; exp_ov = 1'b0;
          check("rnd_clr_fe", 32'(frame_err), 32'h0);
          check("rnd_clr_ov", 32'(overrun), 32'h0);
        end
        tick(gap * CPB);
      end
    end
    rx = 1'b1; tick(CPB);
    compare_q("rnd");
    check("no_consecutive_valid", 32'(consec_viol), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
